test_hu_moment_accum: RTL and testbench

Downstream neighbour of the 8×14→22-bit Hu moment multiplier. It tracks sample valid/last flags through the multiplier's 4-cycle pipeline and accumulates the aligned 22-bit products over one frame. At end of frame it presents one raw moment sum, with a sample count, on a valid/ready output. It feeds the Hu invariant normalisation stage.

---
 rtl/test_hu_moment_accum_pkg.sv | 21 ++
 rtl/test_hu_moment_accum_if.sv | 26 ++
 rtl/test_hu_moment_accum_flag_delay.sv | 42 ++++
 rtl/test_hu_moment_accum.sv | 131 +++++++++++++
 tb/tb_test_hu_moment_accum.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/test_hu_moment_accum_pkg.sv
// Shared constants, output FSM encoding and the frame-result record for the
// Hu moment accumulator and the normalisation stage that consumes its results.
package test_Hu_pkg;

    localparam int MUL_LAT = 4;
    localparam int PROD_W  = 22;
    localparam int CNT_W   = 20;
    localparam int ACC_W   = PROD_W + CNT_W;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             sat;
    } hu_moment_t;

endpackage

// File: rtl/test_hu_moment_accum_if.sv
// Sample stream from the multiplier side plus the valid/ready frame-result port.
interface test_hu_moment_accum_if #(
    parameter int PROD_W = test_Hu_pkg::PROD_W,
    parameter int CNT_W  = test_Hu_pkg::CNT_W,
    parameter int ACC_W  = test_Hu_pkg::ACC_W
);
    logic              ce;
    logic              in_valid;
    logic              in_last;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;

    modport slave (
        input  ce, in_valid, in_last, prod, out_ready,
        output out_valid, out_sum, out_count, out_sat
    );

    modport master (
        output ce, in_valid, in_last, prod, out_ready,
        input  out_valid, out_sum, out_count, out_sat
    );
endinterface

// File: rtl/test_hu_moment_accum_flag_delay.sv
// ce-gated valid/last delay line matching the multiplier pipeline depth, so the
// taps line up with the product currently on the multiplier output.
module test_Hu_flag_delay import test_Hu_pkg::*; #(
    parameter int DEPTH = MUL_LAT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    input  logic in_valid,
    input  logic in_last,
    output logic v_tap,
    output logic l_tap
);
    logic [DEPTH-1:0] v_q, v_d, l_q, l_d;

    // Shift only on ce; a last flag without valid never enters the line.
    always_comb begin
        v_d = v_q;
        l_d = l_q;
        if (ce) begin
            v_d = {v_q[DEPTH-2:0], in_valid};
            l_d = {l_q[DEPTH-2:0], in_valid & in_last};
        end else begin
            v_d = v_q;
            l_d = l_q;
        end
    end

    // Delay line registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= {DEPTH{1'b0}};
            l_q <= {DEPTH{1'b0}};
        end else begin
            v_q <= v_d;
            l_q <= l_d;
        end
    end

    assign v_tap = v_q[DEPTH-1];
    assign l_tap = l_q[DEPTH-1];
endmodule

// File: rtl/test_hu_moment_accum.sv
// Accumulates aligned multiplier products over a frame and holds one saturating
// {sum, count, sat} result on a registered valid/ready output.
module test_hu_moment_accum #(
    parameter int MUL_LAT = test_Hu_pkg::MUL_LAT,
    parameter int PROD_W  = test_Hu_pkg::PROD_W,
    parameter int CNT_W   = test_Hu_pkg::CNT_W,
    parameter int ACC_W   = PROD_W + CNT_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    test_hu_moment_accum_if.slave  bus,
    output logic                   overrun,
    input  logic                   clr_overrun
);
    import test_Hu_pkg::*;

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Returns {overflowed, clamped sum}; the product is treated as unsigned.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] p);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
        return s[ACC_W] ? {1'b1, ACC_MAX} : s;
    endfunction

    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{CNT_W{1'b0}}, 1'b1};
        return s[CNT_W] ? {1'b1, CNT_MAX} : s;
    endfunction

    logic             v_tap_s, l_tap_s, hit_s, load_s;
    logic             acc_ov_s, cnt_ov_s, step_sat_s;
    logic [ACC_W-1:0] acc_next_s, acc_q, acc_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_next_s, cnt_q, cnt_d, count_q, count_d;
    logic             sat_f_q, sat_f_d, out_sat_q, out_sat_d;
    logic             overrun_q, overrun_d;
    out_state_e       state_q, state_d;

    test_Hu_flag_delay #(.DEPTH(MUL_LAT)) u_flag_delay (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (bus.ce),
        .in_valid (bus.in_valid),
        .in_last  (bus.in_last),
        .v_tap    (v_tap_s),
        .l_tap    (l_tap_s)
    );

    // Accumulator/counter update; a last sample is folded in and the frame restarts at zero.
    always_comb begin
        hit_s                    = bus.ce & v_tap_s;
        load_s                   = hit_s & l_tap_s;
        {acc_ov_s, acc_next_s}   = sat_add(acc_q, bus.prod);
        {cnt_ov_s, cnt_next_s}   = sat_inc(cnt_q);
        step_sat_s               = acc_ov_s | cnt_ov_s;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_f_d   = sat_f_q;
        sum_d     = sum_q;
        count_d   = count_q;
        out_sat_d = out_sat_q;
        if (load_s) begin
            sum_d     = acc_next_s;
            count_d   = cnt_next_s;
            out_sat_d = sat_f_q | step_sat_s;
            acc_d     = {ACC_W{1'b0}};
            cnt_d     = {CNT_W{1'b0}};
            sat_f_d   = 1'b0;
        end else if (hit_s) begin
            acc_d   = acc_next_s;
            cnt_d   = cnt_next_s;
            sat_f_d = sat_f_q | step_sat_s;
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Output FSM and sticky overrun; a new overwrite beats a same-cycle clear.
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_EMPTY: begin
                if (load_s) state_d = ST_FULL;
                else        state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (load_s)             state_d = ST_FULL;
                else if (bus.out_ready) state_d = ST_EMPTY;
                else                    state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase
        if ((state_q == ST_FULL) && load_s && !bus.out_ready) overrun_d = 1'b1;
        else if (clr_overrun)                                 overrun_d = 1'b0;
        else                                                  overrun_d = overrun_q;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= {ACC_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            sat_f_q   <= 1'b0;
            sum_q     <= {ACC_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            out_sat_q <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= ST_EMPTY;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_f_q   <= sat_f_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            out_sat_q <= out_sat_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
        end
    end

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_sat   = out_sat_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_test_hu_moment_accum.sv
// Self-checking bench: the bench plays the 4-stage multiplier, models frame sums
// in a scoreboard and checks handshake timing, overrun, saturation and reset.
module tb_test_hu_moment_accum;
    localparam int LAT = test_Hu_pkg::MUL_LAT;
    localparam int PW  = test_Hu_pkg::PROD_W;
    // Narrow counter so a saturating frame stays short; sum then saturates at 2^32-1.
    localparam int CW  = 10;
    localparam int AW  = PW + CW;
    localparam logic [63:0] ACC_MAX_TB = (64'd1 << AW) - 64'd1;
    localparam logic [63:0] CNT_MAX_TB = (64'd1 << CW) - 64'd1;
    localparam logic [PW-1:0] PMAX = {PW{1'b1}};

    typedef struct {
        logic [63:0] sum;
        logic [63:0] cnt;
        logic        sat;
    } res_t;

    typedef struct {
        logic          ce;
        logic          v;
        logic          l;
        logic [PW-1:0] p;
        logic          rdy;
        logic          exp_valid;
    } vec_t;

    logic clk, reset_n, overrun, clr_overrun;
    int total = 0;
    int bad = 0;
    res_t sb[$];
    logic [63:0] m_sum, m_cnt;
    logic        m_sat;
    logic [PW-1:0] mpipe [LAT];
    vec_t tbl [21];

    test_hu_moment_accum_if #(.PROD_W(PW), .CNT_W(CW), .ACC_W(AW)) bus ();

    test_hu_moment_accum #(.MUL_LAT(LAT), .PROD_W(PW), .CNT_W(CW), .ACC_W(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, update model, check any accept, then advance the multiplier model.
    task automatic step(input logic c, input logic v, input logic l,
                        input logic [PW-1:0] p, input logic rdy);
        res_t e;
        bus.ce = c; bus.in_valid = v; bus.in_last = l; bus.out_ready = rdy;
        bus.prod = mpipe[LAT-1];
        if (c && v) begin
            m_sum = m_sum + 64'(p);
            if (m_sum > ACC_MAX_TB) begin m_sum = ACC_MAX_TB; m_sat = 1'b1; end
            m_cnt = m_cnt + 64'd1;
            if (m_cnt > CNT_MAX_TB) begin m_cnt = CNT_MAX_TB; m_sat = 1'b1; end
            if (l) begin
                sb.push_back('{m_sum, m_cnt, m_sat});
                m_sum = 64'd0; m_cnt = 64'd0; m_sat = 1'b0;
            end
        end
        if (bus.out_valid && rdy) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected: got sum %0d expected no result", bus.out_sum);
            end else begin
                e = sb.pop_front();
                chk("sb_sum", 64'(bus.out_sum), e.sum);
                chk("sb_count", 64'(bus.out_count), e.cnt);
                chk("sb_sat", 64'(bus.out_sat), 64'(e.sat));
            end
        end
        @(posedge clk);
        if (c) begin
            for (int i = LAT - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
            mpipe[0] = p;
        end
        #1;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            step(1'b1, 1'b0, 1'b0, {PW{1'b0}}, 1'b0);
            n++;
        end
        chk(nm, 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0; clr_overrun = 1'b0;
        bus.ce = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.prod = {PW{1'b0}}; bus.out_ready = 1'b0;
        m_sum = 64'd0; m_cnt = 64'd0; m_sat = 1'b0;
        for (int i = 0; i < LAT; i++) mpipe[i] = {PW{1'b0}};

        // Basic frame then the same frame with ce held low while samples are in flight.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 22'd10, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 22'd20, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 22'd30, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 22'd40, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 22'd10, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 22'd20, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 22'd30, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 22'd40, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 22'd0,  1'b1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_sum", 64'(bus.out_sum), 64'd0);
        chk("reset_count", 64'(bus.out_count), 64'd0);
        chk("reset_sat", 64'(bus.out_sat), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].ce, tbl[i].v, tbl[i].l, tbl[i].p, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_valid));
        end

        // Backpressure: second one-sample frame overwrites the first.
        step(1'b1, 1'b1, 1'b1, 22'd5, 1'b0);
        step(1'b1, 1'b1, 1'b1, 22'd7, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 22'd0, 1'b0);
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_valid", 64'(bus.out_valid), 64'd1);
        chk("ovr_sum", 64'(bus.out_sum), 64'd7);
        void'(sb.pop_front());
        clr_overrun = 1'b1;
        step(1'b1, 1'b0, 1'b0, 22'd0, 1'b0);
        clr_overrun = 1'b0;
        chk("ovr_clear", 64'(overrun), 64'd0);
        chk("ovr_hold_sum", 64'(bus.out_sum), 64'd7);
        step(1'b1, 1'b0, 1'b0, 22'd0, 1'b1);
        chk("ovr_drained", 64'(bus.out_valid), 64'd0);

        // Back-to-back frames with out_ready high: accept and load on the same edge.
        step(1'b1, 1'b1, 1'b1, 22'd5, 1'b1);
        step(1'b1, 1'b1, 1'b1, 22'd7, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 22'd0, 1'b1);
        chk("b2b_first", 64'(bus.out_sum), 64'd5);
        step(1'b1, 1'b0, 1'b0, 22'd0, 1'b1);
        chk("b2b_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_second", 64'(bus.out_sum), 64'd7);
        chk("b2b_overrun", 64'(overrun), 64'd0);
        step(1'b1, 1'b0, 1'b0, 22'd0, 1'b1);

        // Saturating frame of 2^CW+3 full-scale products, then a normal frame.
        for (int i = 0; i < (1 << CW) + 3; i++)
            step(1'b1, 1'b1, (i == (1 << CW) + 2), PMAX, 1'b0);
        wait_valid("sat_wait", 10);
        chk("sat_sum", 64'(bus.out_sum), ACC_MAX_TB);
        chk("sat_count", 64'(bus.out_count), CNT_MAX_TB);
        chk("sat_flag", 64'(bus.out_sat), 64'd1);
        step(1'b1, 1'b0, 1'b0, 22'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 22'd1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 22'd2, 1'b0);
        wait_valid("post_sat_wait", 10);
        chk("post_sat_flag", 64'(bus.out_sat), 64'd0);
        chk("post_sat_sum", 64'(bus.out_sum), 64'd3);
        step(1'b1, 1'b0, 1'b0, 22'd0, 1'b1);

        // Reset with a result held and a partial frame in flight.
        step(1'b1, 1'b1, 1'b1, 22'd9, 1'b0);
        step(1'b1, 1'b1, 1'b0, 22'd1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 22'd2, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 22'd0, 1'b0);
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.out_sum), 64'd0);
        chk("rst_count", 64'(bus.out_count), 64'd0);
        chk("rst_sat", 64'(bus.out_sat), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        sb.delete();
        m_sum = 64'd0; m_cnt = 64'd0; m_sat = 1'b0;
        repeat (2) step(1'b1, 1'b0, 1'b0, 22'd0, 1'b0);
        chk("rst_hold_valid", 64'(bus.out_valid), 64'd0);
        reset_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 22'd3, 1'b0);
        step(1'b1, 1'b0, 1'b1, 22'd50, 1'b0);
        step(1'b1, 1'b1, 1'b1, 22'd4, 1'b0);
        wait_valid("fresh_wait", 10);
        chk("fresh_sum", 64'(bus.out_sum), 64'd7);
        chk("fresh_count", 64'(bus.out_count), 64'd2);
        step(1'b1, 1'b0, 1'b0, 22'd0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 22'd0, 1'b1);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
